ps2_key_tracker: RTL and testbench
==================================

// Module: ps2_key_tracker
// PURPOSE
//  Parametrised successor to the fixed 4-key keyboard decoder. Consumes the byte stream from
//  Ps2Interface (rx_data + one-cycle read_data strobe) and tracks NUM_KEYS configurable keys.
//  Supports make, break (F0) and extended (E0) scan codes. Outputs a held-key bitmap and a
//  press/release event FIFO. Sits between Ps2Interface and game/control logic.
// PARAMETERS
//  NUM_KEYS       4                        number of tracked keys (1..16)
//  KEY_CODES      {9'h023,9'h01B,9'h01C,9'h01D}  NUM_KEYS x 9b; key i = KEY_CODES[9i+:9]
//                                          bit8 = E0-extended flag, [7:0] = scan code (default W,A,S,D; idx0 = 1D)
//  FIFO_DEPTH     4                        event FIFO entries, power of two >= 2
//  TIMEOUT_CYCLES 100000                   prefix-state timeout in clk cycles (>= 2)
// PORTS
//  clk         in   1               system clock
//  rst         in   1               synchronous, active-high reset
//  rx_data     in   8               received PS/2 byte, valid when rx_done = 1
//  rx_done     in   1               one-cycle strobe: rx_data holds a new byte
//  key_held    out  NUM_KEYS        bit i = 1 while key i is held
//  any_key     out  1               OR-reduction of key_held (registered)
//  ev_valid    out  1               event FIFO not empty
//  ev_ready    in   1               consumer pops the head when ev_valid & ev_ready
//  ev_make     out  1               head event: 1 = press, 0 = release
//  ev_idx      out  $clog2(NUM_KEYS)  head event key index; width = 1 when NUM_KEYS = 1
//  ev_overflow out  1               sticky: an event was dropped because the FIFO was full
// BEHAVIOUR
//  Reset: FSM = IDLE, key_held = 0, any_key = 0, FIFO empty (ev_valid = 0), ev_make = 0,
//   ev_idx = 0, ev_overflow = 0, timeout counter = 0. rst overrides every input, including
//   a simultaneous rx_done, and discards any partial prefix sequence.
//  FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Transitions occur on
//   rx_done only:
//   - byte E0 in any state -> EXT (resync)
//   - byte F0: IDLE -> BRK, EXT -> EXT_BRK; BRK and EXT_BRK hold their state
//   - any other byte B -> IDLE, after a lookup with ext = (state is EXT or EXT_BRK) and
//     make = (state is IDLE or EXT)
//  Lookup: matches the key i whose KEY_CODES entry = {ext,B}. If no entry matches, the byte is
//   ignored. If several entries match, the lowest i wins.
//  Key update on a match:
//   - make with key_held[i] = 0: set the bit and push {1,i}
//   - break with key_held[i] = 1: clear the bit and push {0,i}
//   - make on a held key (typematic repeat) or break on a released key: no change, no event
//  Latency: rx_done sampled at edge N -> key_held, any_key and the FIFO contents are updated
//   at edge N, so they are visible in the cycle after the strobe (1 cycle).
//  FIFO: first-word fall-through. ev_make and ev_idx are valid whenever ev_valid = 1.
//   Pop on ev_valid & ev_ready.
//   - push when full with no pop in the same cycle: the new event is dropped, key_held is still
//     updated, and ev_overflow is set (cleared only by rst)
//   - push and pop in the same cycle when full: both are accepted, count unchanged, no overflow
//   - pop when empty: ignored
//   - read and write pointers wrap modulo FIFO_DEPTH
//  Timeout: in any non-IDLE state the counter increments every cycle without rx_done and resets
//   to 0 on rx_done. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and the counter
//   clears. The counter is held at 0 in IDLE.
//  rx_data is ignored when rx_done = 0. Bytes AA/FA/FE/00/FF are not special and fall under the
//   no-match rule.
// TESTING (defaults unless noted)
//  1 1D, F0 1D -> key_held 0001 one cycle after the 1D strobe, then 0000; FIFO pops {1,0},{0,0}
//  2 1D x5 (typematic), then F0 1D -> exactly 2 events; any_key high from the 1st make until the break
//  3 KEY_CODES idx0 = 9'h175: byte 75 alone -> no event; E0 75 -> {1,0}; E0 F0 75 -> {0,0};
//    F0 75 -> no change
//  4 ev_ready = 0, 5 distinct make/break events -> ev_valid = 1, first 4 events retained in order,
//    ev_overflow = 1, key_held reflects all 5 updates
//  5 F0, then TIMEOUT_CYCLES idle cycles, then 1C -> treated as make: key_held[1] = 1
//  6 F0 sent, rst pulsed, then 1B -> make of key 2; assert rst with ev_valid = 1 -> all outputs
//    return to reset values at the next edge

Source files
------------

// File: rtl/ps2_key_tracker.sv
// Generic first-word-fall-through FIFO, plus the PS/2 key tracker that feeds one.
// FIFO: data visible the cycle after the push; tracker: 1-cycle strobe-to-bitmap/event latency.
// FIFO refuses a push only when full with no pop that cycle; tracker drops the event and flags overflow.

module fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_rdy,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_fire;
  logic             pop_fire;

  assign pop_vld   = (count != '0);
  assign pop_fire  = pop_vld & pop_rdy;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign push_rdy  = (count != (AW+1)'(DEPTH)) | pop_fire;
  assign push_fire = push_vld & push_rdy;
  assign pop_dat   = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= push_dat;
  end
endmodule

module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h023, 9'h01B, 9'h01C, 9'h01D},
  parameter int                    FIFO_DEPTH     = 4,
  parameter int                    TIMEOUT_CYCLES = 100000,
  localparam int                   IDX_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic [NUM_KEYS-1:0] key_held,
  output logic                any_key,
  output logic                ev_valid,
  input  logic                ev_ready,
  output logic                ev_make,
  output logic [IDX_W-1:0]    ev_idx,
  output logic                ev_overflow
);
  localparam int          TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TW-1:0]       tmo_cnt;
  logic                tmo_hit;
  logic                is_key_byte;
  logic                lk_ext;
  logic                lk_make;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic [NUM_KEYS-1:0] key_held_nxt;
  logic                ev_push_vld;
  logic [IDX_W:0]      ev_push_dat;
  logic                ev_push_rdy;
  logic [IDX_W:0]      ev_pop_dat;
  logic                ev_pop_vld;

  // A stalled prefix (lost byte) falls back to IDLE so the next code is read as a make.
  assign tmo_hit = (state != IDLE) && !rx_done && (tmo_cnt == TMO_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: E0 always resyncs to EXT, F0 adds the break flag, anything else ends the sequence.
  always_comb begin
    state_nxt = state;
    if (rx_done) begin
      if (rx_data == 8'hE0) begin
        state_nxt = EXT;
      end else if (rx_data == 8'hF0) begin
        case (state)
          IDLE:    state_nxt = BRK;
          EXT:     state_nxt = EXT_BRK;
          default: state_nxt = state;
        endcase
      end else begin
        state_nxt = IDLE;
      end
    end else if (tmo_hit) begin
      state_nxt = IDLE;
    end
  end

  // FSM outputs: lookup qualifiers derived from the prefix already seen.
  always_comb begin
    is_key_byte = rx_done && (rx_data != 8'hE0) && (rx_data != 8'hF0);
    lk_ext      = (state == EXT) || (state == BRK ? 1'b0 : (state == EXT_BRK));
    lk_make     = (state == IDLE) || (state == EXT);
  end

  // Prefix timeout counter: idle in IDLE, restarted by every received byte.
  always_ff @(posedge clk) begin
    if (rst || rx_done || (state == IDLE) || tmo_hit) tmo_cnt <= '0;
    else                                              tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Key lookup: scanning downwards lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[9*i +: 9] == {lk_ext, rx_data}) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Bitmap update: only real edges (press of a free key, release of a held one) make events.
  always_comb begin
    key_held_nxt = key_held;
    ev_push_vld  = 1'b0;
    ev_push_dat  = {lk_make, hit_idx};
    if (is_key_byte && hit) begin
      if (lk_make && !key_held[hit_idx]) begin
        key_held_nxt[hit_idx] = 1'b1;
        ev_push_vld           = 1'b1;
      end else if (!lk_make && key_held[hit_idx]) begin
        key_held_nxt[hit_idx] = 1'b0;
        ev_push_vld           = 1'b1;
      end
    end
  end

  // Held bitmap, its OR-reduction, and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_held    <= '0;
      any_key     <= 1'b0;
      ev_overflow <= 1'b0;
    end else begin
      key_held <= key_held_nxt;
      any_key  <= |key_held_nxt;
      if (ev_push_vld && !ev_push_rdy) ev_overflow <= 1'b1;
    end
  end

  fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_ev_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (ev_push_vld),
    .push_dat (ev_push_dat),
    .push_rdy (ev_push_rdy),
    .pop_vld  (ev_pop_vld),
    .pop_rdy  (ev_ready),
    .pop_dat  (ev_pop_dat)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign ev_valid = ev_pop_vld;
  assign ev_make  = ev_pop_vld & ev_pop_dat[IDX_W];
  assign ev_idx   = ev_pop_vld ? ev_pop_dat[IDX_W-1:0] : '0;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: expected events are queued at stimulus time and
// checked by an independent monitor whenever the DUT hands out an event.
// Key map: idx0=1D, idx1=1C, idx2=1B, idx3=23, idx4=E0 75, idx5=1D (duplicate, must never win).
module tb_ps2_key_tracker;
  localparam int NK = 6;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic [NK-1:0] key_held;
  logic          any_key;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_make;
  logic [2:0]    ev_idx;
  logic          ev_overflow;

  int         checks   = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mon_e;

  always #5 clk = ~clk;

  ps2_key_tracker #(
    .NUM_KEYS       (NK),
    .KEY_CODES      ({9'h01D, 9'h175, 9'h023, 9'h01B, 9'h01C, 9'h01D}),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .key_held    (key_held),
    .any_key     (any_key),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_make     (ev_make),
    .ev_idx      (ev_idx),
    .ev_overflow (ev_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every event the DUT pops must be the next one the stimulus predicted.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        chk("ev_unexpected", {28'd0, ev_make, ev_idx}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ev_head", {28'd0, ev_make, ev_idx}, {28'd0, mon_e});
      end
    end
  end

  task automatic expect_ev(input logic m, input logic [2:0] i);
    exp_q.push_back({m, i});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe one byte; returns just after the edge that consumed it. rx_data keeps the stale byte.
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || ev_valid) && k < 40) begin
      idle(1);
      k++;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_ev_valid"}, ev_valid, 0);
  endtask

  initial begin
    // Reset with a simultaneous strobe: the strobe must be ignored.
    rst      = 1'b1;
    rx_data  = 8'h1D;
    rx_done  = 1'b1;
    ev_ready = 1'b0;
    idle(2);
    rx_done = 1'b0;
    chk("rst_key_held", key_held, 0);
    chk("rst_any_key", any_key, 0);
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_ev_make", ev_make, 0);
    chk("rst_ev_idx", ev_idx, 0);
    chk("rst_ev_overflow", ev_overflow, 0);
    rst      = 1'b0;
    ev_ready = 1'b1;
    idle(1);
    chk("post_rst_key_held", key_held, 0);

    // 1: make / break of key 0; duplicate entry idx5 must lose.
    expect_ev(1'b1, 3'd0);
    send(8'h1D);
    chk("t1_make_held", key_held, 6'b000001);
    chk("t1_make_any", any_key, 1);
    send(8'hF0);
    chk("t1_f0_held", key_held, 6'b000001);
    expect_ev(1'b0, 3'd0);
    send(8'h1D);
    chk("t1_break_held", key_held, 0);
    idle(3);
    chk("t1_stale_data_held", key_held, 0);
    drain("t1");

    // 2: typematic repeats produce no extra events.
    expect_ev(1'b1, 3'd0);
    for (int r = 0; r < 5; r++) begin
      send(8'h1D);
      chk("t2_repeat_any", any_key, 1);
    end
    send(8'hF0);
    chk("t2_f0_any", any_key, 1);
    expect_ev(1'b0, 3'd0);
    send(8'h1D);
    chk("t2_break_any", any_key, 0);
    drain("t2");

    // 3: extended key E0 75 (idx4).
    send(8'h75);
    chk("t3_plain75_held", key_held, 0);
    chk("t3_plain75_valid", ev_valid, 0);
    expect_ev(1'b1, 3'd4);
    send(8'hE0);
    send(8'h75);
    chk("t3_ext_make_held", key_held, 6'b010000);
    expect_ev(1'b0, 3'd4);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t3_ext_break_held", key_held, 0);
    send(8'hF0);
    send(8'h75);
    chk("t3_plain_break_held", key_held, 0);
    chk("t3_plain_break_valid", ev_valid, 0);
    drain("t3");

    // 4: overflow with the consumer stalled.
    ev_ready = 1'b0;
    expect_ev(1'b1, 3'd0); send(8'h1D);
    expect_ev(1'b1, 3'd1); send(8'h1C);
    expect_ev(1'b1, 3'd2); send(8'h1B);
    expect_ev(1'b1, 3'd3); send(8'h23);
    chk("t4_full_no_ovf", ev_overflow, 0);
    send(8'hF0);
    send(8'h1D);
    chk("t4_ovf", ev_overflow, 1);
    chk("t4_held", key_held, 6'b001110);
    chk("t4_valid", ev_valid, 1);
    chk("t4_head", {ev_make, ev_idx}, 4'b1000);
    ev_ready = 1'b1;
    drain("t4a");
    chk("t4_ovf_sticky", ev_overflow, 1);
    // Refill to full, then push and pop in the same cycle: nothing may be lost.
    ev_ready = 1'b0;
    expect_ev(1'b0, 3'd1); send(8'hF0); send(8'h1C);
    expect_ev(1'b0, 3'd2); send(8'hF0); send(8'h1B);
    expect_ev(1'b0, 3'd3); send(8'hF0); send(8'h23);
    expect_ev(1'b1, 3'd4); send(8'hE0); send(8'h75);
    ev_ready = 1'b1;
    expect_ev(1'b1, 3'd0);
    send(8'h1D);
    chk("t4_pushpop_held", key_held, 6'b010001);
    drain("t4b");
    expect_ev(1'b0, 3'd0); send(8'hF0); send(8'h1D);
    expect_ev(1'b0, 3'd4); send(8'hE0); send(8'hF0); send(8'h75);
    chk("t4_all_released", key_held, 0);
    drain("t4c");

    // 5: prefix timeout.
    expect_ev(1'b1, 3'd1);
    send(8'h1C);
    send(8'hF0);
    idle(TO - 2);
    expect_ev(1'b0, 3'd1);
    send(8'h1C);
    chk("t5_before_timeout_held", key_held, 0);
    send(8'hF0);
    idle(TO);
    expect_ev(1'b1, 3'd1);
    send(8'h1C);
    chk("t5_after_timeout_held", key_held, 6'b000010);
    expect_ev(1'b0, 3'd1);
    send(8'hF0);
    send(8'h1C);
    chk("t5_release_held", key_held, 0);
    drain("t5");

    // 6: reset discards a pending prefix, then reset while events are queued.
    send(8'hF0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    expect_ev(1'b1, 3'd2);
    send(8'h1B);
    chk("t6_make_after_rst", key_held, 6'b000100);
    drain("t6a");
    ev_ready = 1'b0;
    send(8'h1D);
    send(8'h1C);
    send(8'h23);
    send(8'hE0);
    send(8'h75);
    send(8'hF0);
    send(8'h1B);
    chk("t6_pre_valid", ev_valid, 1);
    chk("t6_pre_ovf", ev_overflow, 1);
    chk("t6_pre_held", key_held, 6'b011011);
    rst     = 1'b1;
    rx_data = 8'h1C;
    rx_done = 1'b1;
    idle(1);
    chk("t6_rst_key_held", key_held, 0);
    chk("t6_rst_any_key", any_key, 0);
    chk("t6_rst_ev_valid", ev_valid, 0);
    chk("t6_rst_ev_make", ev_make, 0);
    chk("t6_rst_ev_idx", ev_idx, 0);
    chk("t6_rst_ev_overflow", ev_overflow, 0);
    rst      = 1'b0;
    rx_done  = 1'b0;
    ev_ready = 1'b1;
    expect_ev(1'b1, 3'd1);
    send(8'h1C);
    chk("t6_post_rst_held", key_held, 6'b000010);
    expect_ev(1'b0, 3'd1);
    send(8'hF0);
    send(8'h1C);
    drain("t6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
